// File: rtl/asic_cell_bist_if.sv
// Test bus between the BIST sequencer and
// its controller / cell-under-test wrapper.
interface asic_cell_bist_if #(
  parameter int N = 3
);
  logic         start;
  logic         abort;
  logic         resp;
  logic [N-1:0] stim;
  logic         test_en;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   fail_count;
  logic         fail_valid;
  logic [N-1:0] first_fail;

  modport master (
    output start,
    output abort,
    output resp,
    input  stim,
    input  test_en,
    input  busy,
    input  done,
    input  pass,
    input  fail_count,
    input  fail_valid,
    input  first_fail
  );

  modport slave (
    input  start,
    input  abort,
    input  resp,
    output stim,
    output test_en,
    output busy,
    output done,
    output pass,
    output fail_count,
    output fail_valid,
    output first_fail
  );
endinterface

// File: rtl/asic_cell_bist.sv
// Exhaustive BIST for one N-input library cell:
// walks every vector, settles, compares to TRUTH.
module asic_cell_bist #(
  parameter int              N      = 3,
  parameter logic [(1<<N)-1:0] TRUTH = 8'h1F,
  parameter int              SETTLE = 1
) (
  input logic              clk,
  input logic              reset,
  asic_cell_bist_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETL,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0]   LAST_CNT = 4'(SETTLE - 1);
  localparam logic [N-1:0] LAST_VEC = '1;

  state_t       state, state_d;
  logic [N-1:0] stim, stim_d;
  logic [3:0]   cnt, cnt_d;
  logic         busy, busy_d;
  logic         done, done_d;
  logic         pass, pass_d;
  logic [N:0]   fcnt, fcnt_d;
  logic         fval, fval_d;
  logic [N-1:0] ffail, ffail_d;
  logic         miss;

  assign miss = bus.resp != TRUTH[stim];

  // register all sequencer state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      stim  <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
      fcnt  <= '0;
      fval  <= 1'b0;
      ffail <= '0;
    end else begin
      state <= state_d;
      stim  <= stim_d;
      cnt   <= cnt_d;
      busy  <= busy_d;
      done  <= done_d;
      pass  <= pass_d;
      fcnt  <= fcnt_d;
      fval  <= fval_d;
      ffail <= ffail_d;
    end
  end

  // next state and next datapath values
  always_comb begin
    state_d = state;
    stim_d  = stim;
    cnt_d   = cnt;
    busy_d  = busy;
    done_d  = done;
    pass_d  = pass;
    fcnt_d  = fcnt;
    fval_d  = fval;
    ffail_d = ffail;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_SETL;
          stim_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fcnt_d  = '0;
          fval_d  = 1'b0;
          ffail_d = '0;
        end
      end
      S_SETL: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt == LAST_CNT) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_CHECK: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (miss) begin
            fcnt_d = fcnt + 1'b1;
            if (!fval) begin
              fval_d  = 1'b1;
              ffail_d = stim;
            end
          end
          if (stim == LAST_VEC) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fcnt_d == '0);
          end else begin
            state_d = S_SETL;
            stim_d  = stim + 1'b1;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.stim       = stim;
  assign bus.test_en    = busy;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.fail_count = fcnt;
  assign bus.fail_valid = fval;
  assign bus.first_fail = ffail;

endmodule
